controle_multiciclo: RTL and testbench

//  Multicycle RV64 control unit; replaces hand-sequenced datapath control. Fetches from MemoriaInstrucao,

---
 rtl/rv_pkg.sv | 48 ++++
 rtl/gerador_imediato.sv | 20 ++
 rtl/controle_multiciclo.sv | 216 +++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV64 controller: opcodes, funct fields,
// FSM states, write-back mux codes and the decode legality check.
package rv_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_OP    = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_DW  = 3'b011;

   localparam logic [6:0] F7_ADD = 7'h00;
   localparam logic [6:0] F7_SUB = 7'h20;

   localparam logic [1:0] WB_ULA   = 2'd0;
   localparam logic [1:0] WB_MEM   = 2'd1;
   localparam logic [1:0] WB_PC4   = 2'd2;
   localparam logic [1:0] WB_PCIMM = 2'd3;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WBMEM,
      ST_HALT
   } estado_t;

   // Only ld/sd (doubleword), add/sub, addi, jal, jalr and auipc are accepted.
   function automatic logic instr_legal(input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      case (w[6:0])
         OP_LOAD, OP_STORE: ok = (w[14:12] == F3_DW);
         OP_OP:             ok = (w[14:12] == F3_ADD) &&
                                 ((w[31:25] == F7_ADD) || (w[31:25] == F7_SUB));
         OP_IMM:            ok = (w[14:12] == F3_ADD);
         OP_JAL, OP_JALR, OP_AUIPC: ok = 1'b1;
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/gerador_imediato.sv
// Combinational immediate generator: extracts and sign-extends the I, S, J and U
// immediates from the latched instruction word (opcode bits are not needed).
module gerador_imediato
   import rv_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:7]     ir,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_j,
   output logic [XLEN-1:0] imm_u
);

   assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
   assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
   assign imm_u = {{(XLEN-32){ir[31]}}, ir[31:12], 12'b0};

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RV64 control unit: sequences fetch/decode/execute, owns the PC and
// instruction register, and drives regfile, ULA and data-memory control ports.
module controle_multiciclo
   import rv_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int IMEM_AW = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic [XLEN-1:0]    doutULA,
   output logic [IMEM_AW-1:0] endr,
   output logic [4:0]         Ra,
   output logic [4:0]         Rb,
   output logic [4:0]         Rw,
   output logic               WeR,
   output logic               WeM,
   output logic               soma_ou_subtrai,
   output logic               subtraindo,
   output logic               imediato,
   output logic [XLEN-1:0]    constante,
   output logic [1:0]         wb_sel,
   output logic [XLEN-1:0]    wb_pc,
   output logic [XLEN-1:0]    pc,
   output logic               halt
);

   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
   localparam logic [XLEN-1:0] LSB_CLEAR = ~XLEN'(1);

   estado_t         state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic            halt_q, halt_d;

   logic [XLEN-1:0] imm_i, imm_s, imm_j, imm_u;
   logic [XLEN-1:0] pc_plus4, jal_target, jalr_target;
   logic [6:0]      opcode;
   logic [4:0]      rd, rs1, rs2;
   logic            rd_nz;

   gerador_imediato #(.XLEN(XLEN)) u_imm (
      .ir    (ir_q[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_j (imm_j),
      .imm_u (imm_u)
   );

   assign opcode      = ir_q[6:0];
   assign rd          = ir_q[11:7];
   assign rs1         = ir_q[19:15];
   assign rs2         = ir_q[24:20];
   assign rd_nz       = (rd != 5'd0);
   assign pc_plus4    = pc_q + PC_STEP;
   assign jal_target  = pc_q + imm_j;
   assign jalr_target = doutULA & LSB_CLEAR;

   assign pc   = pc_q;
   assign halt = halt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         halt_q  <= halt_d;
      end
   end

   // Outputs are held at zero while reset is high so an aborted instruction
   // cannot emit a write pulse in the reset cycle itself.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_d            = ir_q;
      halt_d          = halt_q;
      endr            = '0;
      Ra              = 5'd0;
      Rb              = 5'd0;
      Rw              = 5'd0;
      WeR             = 1'b0;
      WeM             = 1'b0;
      soma_ou_subtrai = 1'b0;
      subtraindo      = 1'b0;
      imediato        = 1'b0;
      constante       = '0;
      wb_sel          = WB_ULA;
      wb_pc           = '0;

      if (!reset) begin
         endr = pc_q[IMEM_AW+1:2];
         case (state_q)
            ST_FETCH: begin
               state_d = ST_DECODE;
            end

            ST_DECODE: begin
               ir_d = instr;
               if (instr_legal(instr)) begin
                  state_d = ST_EXEC;
               end else begin
                  state_d = ST_HALT;
                  halt_d  = 1'b1;
               end
            end

            ST_EXEC: begin
               Ra              = rs1;
               Rb              = rs2;
               Rw              = rd;
               soma_ou_subtrai = 1'b1;
               state_d         = ST_FETCH;
               case (opcode)
                  OP_OP: begin
                     subtraindo = ir_q[30];
                     WeR        = rd_nz;
                     pc_d       = pc_plus4;
                  end
                  OP_IMM: begin
                     imediato  = 1'b1;
                     constante = imm_i;
                     WeR       = rd_nz;
                     pc_d      = pc_plus4;
                  end
                  OP_LOAD: begin
                     imediato  = 1'b1;
                     constante = imm_i;
                     state_d   = ST_MEM;
                  end
                  OP_STORE: begin
                     imediato  = 1'b1;
                     constante = imm_s;
                     WeM       = 1'b1;
                     pc_d      = pc_plus4;
                  end
                  OP_JAL: begin
                     wb_pc  = pc_plus4;
                     wb_sel = WB_PC4;
                     if (jal_target[1]) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                     end else begin
                        WeR  = rd_nz;
                        pc_d = jal_target;
                     end
                  end
                  OP_JALR: begin
                     imediato  = 1'b1;
                     constante = imm_i;
                     wb_pc     = pc_plus4;
                     wb_sel    = WB_PC4;
                     if (jalr_target[1]) begin
                        state_d = ST_HALT;
                        halt_d  = 1'b1;
                     end else begin
                        WeR  = rd_nz;
                        pc_d = jalr_target;
                     end
                  end
                  OP_AUIPC: begin
                     wb_pc  = pc_q + imm_u;
                     wb_sel = WB_PCIMM;
                     WeR    = rd_nz;
                     pc_d   = pc_plus4;
                  end
                  default: begin
                     state_d = ST_HALT;
                     halt_d  = 1'b1;
                  end
               endcase
            end

            // Address controls stay up so the synchronous data memory sees a
            // stable address and its read data is ready for write-back.
            ST_MEM: begin
               Ra              = rs1;
               Rb              = rs2;
               Rw              = rd;
               soma_ou_subtrai = 1'b1;
               imediato        = 1'b1;
               constante       = imm_i;
               state_d         = ST_WBMEM;
            end

            ST_WBMEM: begin
               Ra              = rs1;
               Rb              = rs2;
               Rw              = rd;
               soma_ou_subtrai = 1'b1;
               imediato        = 1'b1;
               constante       = imm_i;
               wb_sel          = WB_MEM;
               WeR             = rd_nz;
               pc_d            = pc_plus4;
               state_d         = ST_FETCH;
            end

            ST_HALT: begin
               state_d = ST_HALT;
            end

            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench: wraps the controller with small regfile, ULA, data and instruction
// memory models; expected register/memory writes are queued and popped on each write.
module tb_controle_multiciclo;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr;
   logic [63:0] doutULA;
   logic [6:0]  endr;
   logic [4:0]  Ra, Rb, Rw;
   logic        WeR, WeM, soma_ou_subtrai, subtraindo, imediato, halt;
   logic [63:0] constante, wb_pc, pc;
   logic [1:0]  wb_sel;

   always #5 clk = ~clk;

   controle_multiciclo dut (
      .clk             (clk),
      .reset           (reset),
      .instr           (instr),
      .doutULA         (doutULA),
      .endr            (endr),
      .Ra              (Ra),
      .Rb              (Rb),
      .Rw              (Rw),
      .WeR             (WeR),
      .WeM             (WeM),
      .soma_ou_subtrai (soma_ou_subtrai),
      .subtraindo      (subtraindo),
      .imediato        (imediato),
      .constante       (constante),
      .wb_sel          (wb_sel),
      .wb_pc           (wb_pc),
      .pc              (pc),
      .halt            (halt)
   );

   // Datapath models
   logic [31:0] imem [128];
   logic [63:0] regs [32];
   logic [63:0] dmem [64];
   logic        mem_clr;
   logic [63:0] ra_val, rb_val, ula_b, doutM, din;
   logic [5:0]  dm_addr;

   assign ra_val  = regs[Ra];
   assign rb_val  = regs[Rb];
   assign ula_b   = imediato ? constante : rb_val;
   assign doutULA = subtraindo ? (ra_val - ula_b) : (ra_val + ula_b);
   assign dm_addr = doutULA[8:3];

   always_comb begin
      din = wb_pc;
      case (wb_sel)
         2'd0:    din = doutULA;
         2'd1:    din = doutM;
         default: din = wb_pc;
      endcase
   end

   always @(posedge clk) begin
      instr <= imem[endr];
      doutM <= dmem[dm_addr];
      if (mem_clr) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
         for (int i = 0; i < 64; i++) dmem[i] <= '0;
      end else begin
         if (WeM) dmem[dm_addr] <= rb_val;
         if (WeR && (Rw != 5'd0)) regs[Rw] <= din;
      end
   end

   // Scoreboard
   typedef struct packed { logic [4:0] rd; logic [63:0] val; } wr_t;
   typedef struct packed { logic [5:0] addr; logic [63:0] val; } mw_t;
   wr_t exp_wr[$];
   mw_t exp_mw[$];

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      wr_t e;
      mw_t m;
      if (WeR || WeM) check_eq("we_excl", {63'd0, WeR & WeM}, 64'd0);
      if (WeR) begin
         $display("t=%0t WR x%0d <= %h", $time, Rw, din);
         if (exp_wr.size() == 0) begin
            check_eq("wr_unexpected", {63'd0, WeR}, 64'd0);
         end else begin
            e = exp_wr.pop_front();
            check_eq("wr_rd", 64'(Rw), 64'(e.rd));
            check_eq("wr_val", din, e.val);
         end
      end
      if (WeM) begin
         $display("t=%0t MW [%0d] <= %h", $time, dm_addr, rb_val);
         if (exp_mw.size() == 0) begin
            check_eq("mw_unexpected", {63'd0, WeM}, 64'd0);
         end else begin
            m = exp_mw.pop_front();
            check_eq("mw_addr", 64'(dm_addr), 64'(m.addr));
            check_eq("mw_val", rb_val, m.val);
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push_wr(input logic [4:0] rd, input logic [63:0] v);
      wr_t e;
      e.rd  = rd;
      e.val = v;
      exp_wr.push_back(e);
   endtask

   task automatic push_mw(input logic [5:0] a, input logic [63:0] v);
      mw_t m;
      m.addr = a;
      m.val  = v;
      exp_mw.push_back(m);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 128; i++) imem[i] = 32'hFFFF_FFFF;
   endtask

   // Instruction encoders
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
      return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0010111};
   endfunction

   localparam logic [6:0] OPI  = 7'b0010011;
   localparam logic [6:0] OPLD = 7'b0000011;
   localparam logic [6:0] OPJR = 7'b1100111;

   initial begin
      mem_clr = 1'b1;
      clear_imem();
      reset = 1'b1;
      tick();
      tick();
      mem_clr = 1'b0;

      // Reset state
      check_eq("rst_pc", pc, 64'd0);
      check_eq("rst_halt", {63'd0, halt}, 64'd0);
      check_eq("rst_wer", {63'd0, WeR}, 64'd0);
      check_eq("rst_wem", {63'd0, WeM}, 64'd0);
      check_eq("rst_soma", {63'd0, soma_ou_subtrai}, 64'd0);
      check_eq("rst_endr", 64'(endr), 64'd0);
      check_eq("rst_const", constante, 64'd0);
      check_eq("rst_wbsel", 64'(wb_sel), 64'd0);

      // Arithmetic, store, load, illegal
      clear_imem();
      imem[0] = enc_i(12'd7, 5'd0, 3'd0, 5'd1, OPI);
      imem[1] = enc_i(12'd3, 5'd0, 3'd0, 5'd2, OPI);
      imem[2] = enc_r(7'h00, 5'd2, 5'd1, 5'd3);
      imem[3] = enc_r(7'h20, 5'd2, 5'd1, 5'd4);
      imem[4] = enc_s(12'd40, 5'd1, 5'd0);
      imem[5] = enc_i(12'd40, 5'd0, 3'b011, 5'd5, OPLD);
      reset_dut();
      push_wr(5'd1, 64'd7);
      push_wr(5'd2, 64'd3);
      push_wr(5'd3, 64'd10);
      push_wr(5'd4, 64'd4);
      push_mw(6'd5, 64'd7);
      push_wr(5'd5, 64'd7);
      run(12);
      check_eq("arith_pc", pc, 64'd16);
      check_eq("x3", regs[3], 64'd10);
      check_eq("x4", regs[4], 64'd4);
      run(3);
      check_eq("sd_pc", pc, 64'd20);
      check_eq("dmem5", dmem[5], 64'd7);
      run(4);
      check_eq("ld_pc_4cyc", pc, 64'd20);
      run(1);
      check_eq("ld_pc_5cyc", pc, 64'd24);
      check_eq("x5", regs[5], 64'd7);
      run(1);
      check_eq("halt_pre", {63'd0, halt}, 64'd0);
      run(1);
      check_eq("halt_set", {63'd0, halt}, 64'd1);
      run(4);
      check_eq("halt_pc", pc, 64'd24);
      check_eq("halt_hold", {63'd0, halt}, 64'd1);

      // jal / jalr
      clear_imem();
      imem[0] = enc_j(21'd8, 5'd6);
      imem[2] = enc_i(12'd0, 5'd6, 3'd0, 5'd7, OPJR);
      reset_dut();
      check_eq("rst2_halt", {63'd0, halt}, 64'd0);
      push_wr(5'd6, 64'd4);
      push_wr(5'd7, 64'd12);
      run(3);
      check_eq("jal_pc", pc, 64'd8);
      run(3);
      check_eq("jalr_pc", pc, 64'd4);
      check_eq("x7", regs[7], 64'd12);
      run(2);
      check_eq("halt_at4", {63'd0, halt}, 64'd1);
      run(3);
      check_eq("halt_pc4", pc, 64'd4);

      // x0 write suppressed, auipc
      clear_imem();
      imem[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPI);
      imem[1] = enc_i(12'd1, 5'd0, 3'd0, 5'd9, OPI);
      imem[2] = enc_u(20'd1, 5'd8);
      reset_dut();
      push_wr(5'd9, 64'd1);
      push_wr(5'd8, 64'h1008);
      run(3);
      check_eq("x0_pc", pc, 64'd4);
      check_eq("x0", regs[0], 64'd0);
      run(6);
      check_eq("auipc_pc", pc, 64'd12);
      check_eq("x8", regs[8], 64'h1008);
      run(2);
      check_eq("halt_c", {63'd0, halt}, 64'd1);

      // Misaligned jal target
      clear_imem();
      imem[0] = enc_j(21'd6, 5'd10);
      reset_dut();
      run(3);
      check_eq("jal_mis_halt", {63'd0, halt}, 64'd1);
      check_eq("jal_mis_pc", pc, 64'd0);
      check_eq("x10", regs[10], 64'd0);

      // Misaligned jalr target (x6 holds 4 from the jal test)
      clear_imem();
      imem[0] = enc_i(12'd2, 5'd6, 3'd0, 5'd11, OPJR);
      reset_dut();
      run(3);
      check_eq("jalr_mis_halt", {63'd0, halt}, 64'd1);
      check_eq("jalr_mis_pc", pc, 64'd0);
      check_eq("x11", regs[11], 64'd0);

      // Reset during MEM of ld
      clear_imem();
      imem[0] = enc_i(12'd40, 5'd0, 3'b011, 5'd12, OPLD);
      reset_dut();
      run(3);
      check_eq("in_mem_soma", {63'd0, soma_ou_subtrai}, 64'd1);
      reset = 1'b1;
      #1;
      check_eq("abort_wer", {63'd0, WeR}, 64'd0);
      check_eq("abort_wem", {63'd0, WeM}, 64'd0);
      tick();
      reset = 1'b0;
      #1;
      check_eq("abort_pc", pc, 64'd0);
      check_eq("abort_fetch_soma", {63'd0, soma_ou_subtrai}, 64'd0);
      check_eq("abort_wer2", {63'd0, WeR}, 64'd0);
      tick();
      check_eq("abort_x12", regs[12], 64'd0);
      push_wr(5'd12, 64'd7);
      run(4);
      check_eq("rerun_pc", pc, 64'd4);
      check_eq("rerun_x12", regs[12], 64'd7);
      run(2);
      check_eq("halt_f", {63'd0, halt}, 64'd1);

      check_eq("wr_q_empty", 64'(exp_wr.size()), 64'd0);
      check_eq("mw_q_empty", 64'(exp_mw.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
